signed_div32x16_seq: RTL and testbench
======================================

SIGNED_DIV32X16_SEQ -- requirements
Module: signed_div32x16_seq

Interface
REQ-001 SHALL have no parameters; all widths are fixed as listed below.
REQ-002 SHALL have sys_clk  input  1  rising-edge clock for all state.
REQ-003 SHALL have sys_rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have en  input  1  synchronous enable; low = abort and clear (REQ-024).
REQ-005 SHALL have in_valid  input  1  operand pair offered.
REQ-006 SHALL have in_ready  output  1  block idle and able to accept operands.
REQ-007 SHALL have dividend  input  32  signed two's-complement dividend.
REQ-008 SHALL have divisor  input  16  signed two's-complement divisor.
REQ-009 SHALL have out_valid  output  1  result registers hold a valid result.
REQ-010 SHALL have out_ready  input  1  downstream accepts the result.
REQ-011 SHALL have quotient  output  32  signed quotient, truncated toward zero.
REQ-012 SHALL have remainder  output  16  signed remainder, sign of the dividend.
REQ-013 SHALL have div_by_zero  output  1  result flag: divisor was 0.
REQ-014 SHALL have overflow  output  1  result flag: dividend -2^31 with divisor -1.

Function
REQ-015 SHALL use FSM states IDLE, PREP, CALC, FIX, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 SHALL accept operands on the rising edge where in_valid && in_ready && en, register dividend/divisor, and enter PREP.
REQ-017 PREP (1 cycle) SHALL latch result signs, form |dividend| (33-bit safe) and |divisor| (17-bit safe), clear the partial remainder, load the iteration counter with 31, and enter CALC.
REQ-018 PREP SHALL detect the special cases: divisor==0 -> quotient=0x7FFFFFFF when dividend>=0 else 0x80000000, remainder=dividend[15:0], div_by_zero=1; dividend==0x80000000 && divisor==0xFFFF -> quotient=0x7FFFFFFF, remainder=0, overflow=1. It SHALL then go directly to DONE, so out_valid is first high 2 edges after accept.
REQ-019 CALC SHALL perform one radix-2 restoring (or non-restoring) step per cycle for exactly 32 cycles, MSB first, on unsigned magnitudes; the counter decrements each cycle; at counter==0 the FSM SHALL enter FIX.
REQ-020 FIX (1 cycle) SHALL negate the quotient magnitude when operand signs differ and negate the remainder magnitude when the dividend is negative, load the output registers with both flags 0, and enter DONE. out_valid is first high exactly 35 edges after the accept edge (1 PREP + 32 CALC + 1 FIX + 1).
REQ-021 Results SHALL equal Verilog signed '/' and '%' for all non-special operands, with |remainder| < |divisor|. Divisor -32768 SHALL be handled without loss.
REQ-022 In DONE, quotient/remainder/flags SHALL stay stable while out_ready=0; on the edge with out_ready=1 the FSM SHALL return to IDLE. in_ready is low in DONE, so no overlap is possible; the next accept can occur no earlier than the edge after the result handshake.
REQ-023 in_valid during PREP/CALC/FIX/DONE SHALL be ignored (in_ready=0); input changes during computation SHALL NOT affect the result.
REQ-024 en=0 at any rising edge SHALL force IDLE and clear all datapath and output registers to 0, taking priority over every handshake; an in-flight operation is discarded and produces no out_valid.

Reset
REQ-025 sys_rst_n=0 SHALL asynchronously force IDLE, with in_ready=1 after release, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0, and the internal counter and registers 0.
REQ-026 Reset asserted mid-operation SHALL discard the operation; the first accept after release SHALL behave as from power-up.

Verification
REQ-027 Accept dividend=100000, divisor=-7 -> out_valid 35 edges later; quotient=-14285 (0xFFFFC833), remainder=5, flags 0.
REQ-028 Accept dividend=-100000, divisor=7 -> quotient=-14285, remainder=-5; then 65536/-32768 -> quotient=-2, remainder=0.
REQ-029 Accept dividend=1234, divisor=0 -> out_valid 2 edges after accept, div_by_zero=1, quotient=0x7FFFFFFF, remainder=0x04D2.
REQ-030 Accept 0x80000000 / 0xFFFF -> overflow=1, quotient=0x7FFFFFFF, remainder=0; -2^31 / 1 -> quotient=0x80000000, overflow=0.
REQ-031 Hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0 throughout; pulse out_ready -> IDLE next edge. Drive in_valid continuously with changing operands -> only the pair sampled at accept is used.
REQ-032 Drop en for 1 cycle at CALC iteration 10, then separately assert sys_rst_n low mid-CALC -> IDLE with all outputs 0 and no out_valid; a following 42/5 -> quotient=8, remainder=2.

Source files
------------

// File: rtl/signed_div32x16_seq.sv
// Sequential signed 32/16 divider: one restoring radix-2 step per cycle on
// operand magnitudes, with sign fix-up and divide-by-zero / overflow handling.
module signed_div32x16_seq (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               en,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic signed [31:0] dividend,
  input  logic signed [15:0] divisor,
  output logic               out_valid,
  input  logic               out_ready,
  output logic signed [31:0] quotient,
  output logic signed [15:0] remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_t;

  state_t             state_q, state_d;
  logic signed [31:0] dvd_q, dvd_d;
  logic signed [15:0] dvs_q, dvs_d;
  logic [31:0]        mag_q, mag_d;    // dividend magnitude, shifts out MSB and takes quotient bits in
  logic [16:0]        dmag_q, dmag_d;  // divisor magnitude; 17 bits so -32768 stays exact
  logic [15:0]        rem_q, rem_d;    // partial remainder, always < |divisor| <= 32768
  logic [4:0]         cnt_q, cnt_d;
  logic               negq_q, negq_d;
  logic               negr_q, negr_d;
  logic signed [31:0] quo_q, quo_d;
  logic signed [15:0] rm_q, rm_d;
  logic               dbz_q, dbz_d;
  logic               ovf_q, ovf_d;
  logic [16:0]        rem_sh;

  // Magnitude of a 32-bit two's-complement value; -2^31 maps to 2^31 unsigned.
  function automatic logic [31:0] abs32(input logic signed [31:0] v);
    logic [31:0] u;
    u = v;
    return v[31] ? (~u + 32'd1) : u;
  endfunction

  // Magnitude of a 16-bit value, widened so -32768 becomes +32768.
  function automatic logic [16:0] abs17(input logic signed [15:0] v);
    logic [16:0] u;
    u = {v[15], v};
    return v[15] ? (~u + 17'd1) : u;
  endfunction

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign quotient    = quo_q;
  assign remainder   = rm_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;

  // Next-state and datapath updates; en low clears everything and wins over handshakes.
  always_comb begin
    state_d = state_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    mag_d   = mag_q;
    dmag_d  = dmag_q;
    rem_d   = rem_q;
    cnt_d   = cnt_q;
    negq_d  = negq_q;
    negr_d  = negr_q;
    quo_d   = quo_q;
    rm_d    = rm_q;
    dbz_d   = dbz_q;
    ovf_d   = ovf_q;
    rem_sh  = {rem_q, mag_q[31]};
    if (!en) begin
      state_d = IDLE;
      dvd_d   = '0;
      dvs_d   = '0;
      mag_d   = '0;
      dmag_d  = '0;
      rem_d   = '0;
      cnt_d   = '0;
      negq_d  = 1'b0;
      negr_d  = 1'b0;
      quo_d   = '0;
      rm_d    = '0;
      dbz_d   = 1'b0;
      ovf_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            dvd_d   = dividend;
            dvs_d   = divisor;
            state_d = PREP;
          end
        end
        PREP: begin
          negq_d = dvd_q[31] ^ dvs_q[15];
          negr_d = dvd_q[31];
          mag_d  = abs32(dvd_q);
          dmag_d = abs17(dvs_q);
          rem_d  = '0;
          cnt_d  = 5'd31;
          if (dvs_q == 16'sd0) begin
            quo_d   = dvd_q[31] ? 32'sh8000_0000 : 32'sh7FFF_FFFF;
            rm_d    = dvd_q[15:0];
            dbz_d   = 1'b1;
            ovf_d   = 1'b0;
            state_d = DONE;
          end else if (dvd_q == 32'sh8000_0000 && dvs_q == 16'shFFFF) begin
            quo_d   = 32'sh7FFF_FFFF;
            rm_d    = '0;
            dbz_d   = 1'b0;
            ovf_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
        CALC: begin
          if (rem_sh >= dmag_q) begin
            rem_d = 16'(rem_sh - dmag_q);
            mag_d = {mag_q[30:0], 1'b1};
          end else begin
            rem_d = rem_sh[15:0];
            mag_d = {mag_q[30:0], 1'b0};
          end
          if (cnt_q == 5'd0) begin
            state_d = FIX;
          end else begin
            cnt_d = cnt_q - 5'd1;
          end
        end
        FIX: begin
          quo_d   = negq_q ? (32'd0 - mag_q) : mag_q;
          rm_d    = negr_q ? (16'd0 - rem_q) : rem_q;
          dbz_d   = 1'b0;
          ovf_d   = 1'b0;
          state_d = DONE;
        end
        DONE: begin
          if (out_ready) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and datapath registers, all cleared by the asynchronous reset.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q <= IDLE;
      dvd_q   <= '0;
      dvs_q   <= '0;
      mag_q   <= '0;
      dmag_q  <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      quo_q   <= '0;
      rm_q    <= '0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      mag_q   <= mag_d;
      dmag_q  <= dmag_d;
      rem_q   <= rem_d;
      cnt_q   <= cnt_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      quo_q   <= quo_d;
      rm_q    <= rm_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule

// File: tb/tb_signed_div32x16_seq.sv
// Directed bench for signed_div32x16_seq with hand-computed expected results.
module tb_signed_div32x16_seq;

  logic               sys_clk;
  logic               sys_rst_n;
  logic               en;
  logic               in_valid;
  logic               in_ready;
  logic signed [31:0] dividend;
  logic signed [15:0] divisor;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] quotient;
  logic signed [15:0] remainder;
  logic               div_by_zero;
  logic               overflow;

  int n_checks = 0;
  int n_errors = 0;

  signed_div32x16_seq dut (
    .sys_clk    (sys_clk),
    .sys_rst_n  (sys_rst_n),
    .en         (en),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .dividend   (dividend),
    .divisor    (divisor),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero),
    .overflow   (overflow)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Offer an operand pair at a falling edge; it is accepted on the next rising edge.
  task automatic start_op(input logic signed [31:0] dvd, input logic signed [15:0] dvs,
                          input bit keep_valid);
    @(negedge sys_clk);
    chk("in_ready_before_accept", {31'd0, in_ready}, 32'd1);
    dividend = dvd;
    divisor  = dvs;
    in_valid = 1'b1;
    @(posedge sys_clk);
    #1;
    if (!keep_valid) in_valid = 1'b0;
  endtask

  // Count edges from accept until out_valid is seen; 0 means it never came.
  task automatic wait_result(input bit scramble, output int lat);
    lat = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge sys_clk);
      if (out_valid) begin
        lat = k;
        break;
      end
      if (scramble) begin
        dividend = $urandom;
        divisor  = 16'($urandom);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge sys_clk);
    #1;
    out_ready = 1'b0;
    chk("idle_after_handshake", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic op(input string tag, input logic signed [31:0] dvd, input logic signed [15:0] dvs,
                    input int exp_lat, input logic [31:0] exp_q, input logic [15:0] exp_r,
                    input logic exp_dbz, input logic exp_ovf);
    int lat;
    start_op(dvd, dvs, 1'b0);
    wait_result(1'b0, lat);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_quotient"}, quotient, exp_q);
    chk({tag, "_remainder"}, {16'd0, remainder}, {16'd0, exp_r});
    chk({tag, "_div_by_zero"}, {31'd0, div_by_zero}, {31'd0, exp_dbz});
    chk({tag, "_overflow"}, {31'd0, overflow}, {31'd0, exp_ovf});
    handshake();
  endtask

  task automatic expect_no_valid(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge sys_clk);
      if (out_valid) seen++;
    end
    chk(tag, seen, 0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_quotient"}, quotient, 32'd0);
    chk({tag, "_remainder"}, {16'd0, remainder}, 32'd0);
    chk({tag, "_flags"}, {30'd0, div_by_zero, overflow}, 32'd0);
  endtask

  initial begin
    int lat;
    sys_rst_n = 1'b0;
    en        = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    #3;
    check_cleared("reset");
    @(negedge sys_clk);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;

    op("p100000_m7", 32'sd100000, -16'sd7, 35, 32'hFFFF_C833, 16'd5, 1'b0, 1'b0);
    op("m100000_p7", -32'sd100000, 16'sd7, 35, 32'hFFFF_C833, 16'hFFFB, 1'b0, 1'b0);
    op("65536_m32768", 32'sd65536, -16'sd32768, 35, 32'hFFFF_FFFE, 16'd0, 1'b0, 1'b0);
    op("div0_pos", 32'sd1234, 16'sd0, 2, 32'h7FFF_FFFF, 16'h04D2, 1'b1, 1'b0);
    op("div0_neg", -32'sd5, 16'sd0, 2, 32'h8000_0000, 16'hFFFB, 1'b1, 1'b0);
    op("ovf", 32'sh8000_0000, 16'shFFFF, 2, 32'h7FFF_FFFF, 16'd0, 1'b0, 1'b1);
    op("min_div_1", 32'sh8000_0000, 16'sd1, 35, 32'h8000_0000, 16'd0, 1'b0, 1'b0);
    op("min_div_m32768", 32'sh8000_0000, -16'sd32768, 35, 32'h0001_0000, 16'd0, 1'b0, 1'b0);
    op("max_div_m32768", 32'sh7FFF_FFFF, -16'sd32768, 35, 32'hFFFF_0001, 16'h7FFF, 1'b0, 1'b0);
    op("7_div_m32768", 32'sd7, -16'sd32768, 35, 32'h0000_0000, 16'd7, 1'b0, 1'b0);
    op("m1_div_2", -32'sd1, 16'sd2, 35, 32'h0000_0000, 16'hFFFF, 1'b0, 1'b0);

    // Result held while downstream stalls.
    start_op(32'sd1000, 16'sd3, 1'b0);
    wait_result(1'b0, lat);
    chk("hold_latency", lat, 35);
    for (int k = 0; k < 10; k++) begin
      @(negedge sys_clk);
      chk("hold_quotient", quotient, 32'd333);
      chk("hold_remainder", {16'd0, remainder}, 32'd1);
      chk("hold_valid_ready", {30'd0, out_valid, in_ready}, 32'd2);
    end
    handshake();
    chk("hold_valid_dropped", {31'd0, out_valid}, 32'd0);

    // Operands change every cycle after accept; only the accepted pair counts.
    start_op(32'sd42, 16'sd5, 1'b1);
    wait_result(1'b1, lat);
    chk("scramble_latency", lat, 35);
    chk("scramble_quotient", quotient, 32'd8);
    chk("scramble_remainder", {16'd0, remainder}, 32'd2);
    handshake();

    // en dropped for one cycle in the middle of CALC.
    start_op(32'sd100000, 16'sd7, 1'b0);
    repeat (11) @(negedge sys_clk);
    en = 1'b0;
    @(posedge sys_clk);
    #1;
    en = 1'b1;
    check_cleared("en_abort");
    expect_no_valid("en_abort_no_valid", 40);

    // Asynchronous reset in the middle of CALC.
    start_op(-32'sd100000, 16'sd7, 1'b0);
    repeat (15) @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_cleared("rst_abort");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    expect_no_valid("rst_abort_no_valid", 40);

    op("after_abort_42_5", 32'sd42, 16'sd5, 35, 32'd8, 16'd2, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
